// File: rtl/fir_mac_serial.sv
// rtl/fir_mac_serial.sv - serial-MAC FIR filter with loadable coefficients (option: FIR_MAC_SAT_EN)
module fir_mac_serial #(
    parameter int BITS  = 8,
    parameter int TAPS  = 4,
    parameter int CBITS = 8,
    parameter int SHIFT = CBITS - 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [BITS-1:0]  x,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic signed [CBITS-1:0] coef_data,
    output logic                    out_valid,
    output logic signed [BITS-1:0]  y,
    output logic                    busy
);

    localparam int IW   = $clog2(TAPS);
    localparam int ACCW = BITS + CBITS + $clog2(TAPS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]              r_state;
    logic signed [BITS-1:0]  r_samples [TAPS];
    logic signed [CBITS-1:0] r_coef    [TAPS];
    logic signed [ACCW-1:0]  r_acc;
    logic [IW-1:0]           r_idx;
    logic signed [BITS-1:0]  r_y;
    logic                    r_out_valid;

    logic signed [BITS+CBITS-1:0] w_prod;
    logic signed [ACCW-1:0]       w_shifted;
    logic signed [BITS-1:0]       w_narrow;

    // One multiplier shared across all taps, indexed by the MAC step counter
    assign w_prod    = r_samples[r_idx] * r_coef[r_idx];
    assign w_shifted = r_acc >>> SHIFT;

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [ACCW-1:0] YMAX = ACCW'((2 ** (BITS - 1)) - 1);
    localparam logic signed [ACCW-1:0] YMIN = ~YMAX;

    // Clamp the scaled accumulator into the output range
    always_comb begin
        w_narrow = w_shifted[BITS-1:0];
        if (w_shifted > YMAX) begin
            w_narrow = YMAX[BITS-1:0];
        end else if (w_shifted < YMIN) begin
            w_narrow = YMIN[BITS-1:0];
        end
    end
`else
    logic w_unused_hi;

    // Two's-complement wrap: upper bits are simply discarded
    assign w_unused_hi = ^w_shifted[ACCW-1:BITS];
    assign w_narrow    = w_shifted[BITS-1:0];
`endif

    // Sequencer plus datapath: accept a sample, run TAPS MAC steps, publish the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_idx       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_samples[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_samples[0] <= x;
                        for (int i = 1; i < TAPS; i++) begin
                            r_samples[i] <= r_samples[i-1];
                        end
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + ACCW'(w_prod);
                    r_idx <= r_idx + IW'(1);
                    if (r_idx == IW'(TAPS - 1)) begin
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    r_y         <= w_narrow;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Coefficient bank: writes land only while idle so a running MAC never sees a change
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (r_state == S_IDLE && coef_we) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign y         = r_y;

endmodule

// File: tb/tb_fir_mac_serial.sv
// tb/tb_fir_mac_serial.sv - randomized self-checking bench for fir_mac_serial
module tb_fir_mac_serial;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] x;
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic signed [7:0] coef_data;
    logic              out_valid;
    logic signed [7:0] y;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;
    int hist  [4];
    int coefm [4];

    fir_mac_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .y         (y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < 4; k++) begin
            hist[k]  = 0;
            coefm[k] = 0;
        end
    endfunction

    function automatic void model_push(input int xv);
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = xv;
    endfunction

    function automatic int model_y();
        int acc = 0;
        int s;
        logic [7:0] b;
        for (int k = 0; k < 4; k++) acc += hist[k] * coefm[k];
        s = acc >>> 7;
`ifdef FIR_MAC_SAT_EN
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
`else
        b = s[7:0];
        return int'($signed(b));
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic wr_coef(input int a, input int d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 2'(a);
        coef_data = 8'(d);
        @(posedge clk);
        coefm[a] = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Push one sample (optionally with a same-cycle coefficient write) and check timing and y
    task automatic push(input int xv, input bit we, input int wa, input int wd,
                        input string tag, output int yexp);
        int cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_rdy"}, int'(in_ready), 1);
        in_valid  = 1'b1;
        x         = 8'(xv);
        coef_we   = we;
        coef_addr = 2'(wa);
        coef_data = 8'(wd);
        @(posedge clk);
        if (we) coefm[wa] = wd;
        model_push(xv);
        yexp = model_y();
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        check({tag, "_busy0"}, int'(busy), 1);
        check({tag, "_ov0"}, int'(out_valid), 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("%s_busy%0d", tag, k), int'(busy), (k < 5) ? 1 : 0);
            check($sformatf("%s_ov%0d", tag, k), int'(out_valid), (k == 5) ? 1 : 0);
        end
        check({tag, "_y"}, int'(y), yexp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ye;
        int exp_t2 [4] = '{50, 25, 12, 6};
        int t2_x   [4] = '{100, 0, 0, 0};
        int acc_cyc[$];
        int expq[$];
        bit rdy;
        int seen;

        rst_n = 1'b0; in_valid = 1'b0; x = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_clear();

        // 1: reset state and all-zero coefficients
        do_reset();
        check("rst_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_ov", int'(out_valid), 0);
        check("rst_y", int'(y), 0);
        push(10, 0, 0, 0, "t1", ye);
        check("t1_zero", ye, 0);

        // 2: impulse through known coefficients, truncation of shifted result
        do_reset();
        wr_coef(0, 64); wr_coef(1, 32); wr_coef(2, 16); wr_coef(3, 8);
        for (int i = 0; i < 4; i++) begin
            push(t2_x[i], 0, 0, 0, $sformatf("t2_%0d", i), ye);
            check($sformatf("t2_lit%0d", i), int'(y), exp_t2[i]);
        end

        // 4: overflow of the narrowed result
        for (int i = 0; i < 4; i++) wr_coef(i, 127);
        for (int i = 0; i < 4; i++) push(127, 0, 0, 0, $sformatf("t4a_%0d", i), ye);
`ifdef FIR_MAC_SAT_EN
        check("t4a_lit", int'(y), 127);
`else
        check("t4a_lit", int'(y), -8);
`endif
        wr_coef(0, -128); wr_coef(1, 0); wr_coef(2, 0); wr_coef(3, 0);
        push(-128, 0, 0, 0, "t4b", ye);
`ifdef FIR_MAC_SAT_EN
        check("t4b_lit", int'(y), 127);
`else
        check("t4b_lit", int'(y), -128);
`endif

        // 5: in_valid held high; coefficient write while busy must be dropped
        for (int i = 0; i < 4; i++) wr_coef(i, int'($urandom_range(0, 255)) - 128);
        @(negedge clk);
        in_valid = 1'b1;
        x = 8'($urandom_range(0, 255));
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid) begin
                if (expq.size() == 0) check("t5_extra_ov", 1, 0);
                else check("t5_y", int'(y), expq.pop_front());
            end
            rdy = in_ready;
            if (cyc == 8) begin
                check("t5_busy_we", int'(busy), 1);
                coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd99;
            end else begin
                coef_we = 1'b0;
            end
            @(posedge clk);
            if (rdy) begin
                acc_cyc.push_back(cyc);
                model_push(int'(x));
                expq.push_back(model_y());
            end
            @(negedge clk);
            if (rdy) x = 8'($urandom_range(0, 255));
        end
        in_valid = 1'b0;
        coef_we  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                if (expq.size() == 0) check("t5_extra_ov", 1, 0);
                else check("t5_y", int'(y), expq.pop_front());
            end
            @(negedge clk);
        end
        check("t5_naccept", acc_cyc.size(), 4);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("t5_interval", acc_cyc[i] - acc_cyc[i-1], 6);
        check("t5_pending", expq.size(), 0);
        push(int'($urandom_range(0, 255)) - 128, 0, 0, 0, "t5_after", ye);

        // Random: mix of plain pushes and same-cycle coefficient writes
        for (int i = 0; i < 30; i++) begin
            push(int'($urandom_range(0, 255)) - 128, bit'($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128,
                 $sformatf("rnd%0d", i), ye);
        end

        // 6: reset in the middle of a MAC
        @(negedge clk);
        in_valid = 1'b1;
        x = 8'sd55;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("t6_no_ov", seen, 0);
        check("t6_y", int'(y), 0);
        check("t6_ready", int'(in_ready), 1);
        check("t6_busy", int'(busy), 0);
        push(33, 0, 0, 0, "t6_a", ye);
        check("t6_a_zero", int'(y), 0);
        wr_coef(1, 100);
        push(-50, 0, 0, 0, "t6_b", ye);
        check("t6_b_lit", int'(y), 25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
